// File: rtl/kernel_req_capture.sv
// Merges two kernel BRAM-style request ports into one ordered FIFO stream
// with stall, sticky overflow/conflict flags and access counters.
module kernel_req_capture #(
    parameter int ADDR_WID = 16,
    parameter int DATA_WID = 32,
    parameter int DEPTH    = 8,
    parameter int CNT_WID  = 32
) (
    input  logic                    mod_clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    a_ce0,
    input  logic                    a_we0,
    input  logic [ADDR_WID-1:0]     a_addr0,
    input  logic [DATA_WID-1:0]     a_d0,
    input  logic                    a_ce1,
    input  logic                    a_we1,
    input  logic [ADDR_WID-1:0]     a_addr1,
    input  logic [DATA_WID-1:0]     a_d1,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_port,
    output logic                    out_we,
    output logic [ADDR_WID-1:0]     out_addr,
    output logic [DATA_WID-1:0]     out_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    stall,
    output logic                    overflow,
    output logic                    conflict,
    output logic [CNT_WID-1:0]      rd_cnt,
    output logic [CNT_WID-1:0]      wr_cnt,
    output logic [CNT_WID-1:0]      drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_STALL = CW'(DEPTH - 2);

    logic                r_mem_port [DEPTH];
    logic                r_mem_we   [DEPTH];
    logic [ADDR_WID-1:0] r_mem_addr [DEPTH];
    logic [DATA_WID-1:0] r_mem_data [DEPTH];

    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                r_overflow;
    logic                r_conflict;
    logic [CNT_WID-1:0]  r_rd_cnt;
    logic [CNT_WID-1:0]  r_wr_cnt;
    logic [CNT_WID-1:0]  r_drop_cnt;

    logic [1:0]          w_n;
    logic [CW-1:0]       w_free;
    logic                w_accept;
    logic                w_pop;
    logic [1:0]          w_push_n;
    logic [1:0]          w_nrd;
    logic [1:0]          w_nwr;
    logic [1:0]          w_ndrop;
    logic                w_hazard;
    logic [PW-1:0]       w_ptr1;

    // Add 0..2 to a counter, pinning at all-ones instead of wrapping.
    function automatic logic [CNT_WID-1:0] f_sat_add(
        input logic [CNT_WID-1:0] v,
        input logic [1:0]         k
    );
        logic [CNT_WID:0] s;
        s = {1'b0, v} + {{(CNT_WID-1){1'b0}}, k};
        return s[CNT_WID] ? '1 : s[CNT_WID-1:0];
    endfunction

    // Free space is taken before any pop on this edge: no pop credit.
    assign w_n      = {1'b0, a_ce0} + {1'b0, a_ce1};
    assign w_free   = C_DEPTH - r_count;
    assign w_accept = CW'(w_n) <= w_free;
    assign w_pop    = out_valid && out_ready;
    assign w_push_n = w_accept ? w_n : 2'd0;
    assign w_ndrop  = w_accept ? 2'd0 : w_n;
    assign w_nrd    = w_accept ? ({1'b0, a_ce0 && !a_we0}
                                + {1'b0, a_ce1 && !a_we1}) : 2'd0;
    assign w_nwr    = w_accept ? ({1'b0, a_ce0 && a_we0}
                                + {1'b0, a_ce1 && a_we1}) : 2'd0;
    assign w_hazard = a_ce0 && a_ce1 && (a_addr0 == a_addr1)
                    && (a_we0 || a_we1);
    assign w_ptr1   = r_wr_ptr + PW'(a_ce0);

    // Entry storage; port 1 lands behind port 0 when both fire.
    always_ff @(posedge mod_clk) begin
        if (w_accept && a_ce0) begin
            r_mem_port[r_wr_ptr] <= 1'b0;
            r_mem_we[r_wr_ptr]   <= a_we0;
            r_mem_addr[r_wr_ptr] <= a_addr0;
            r_mem_data[r_wr_ptr] <= a_we0 ? a_d0 : '0;
        end
        if (w_accept && a_ce1) begin
            r_mem_port[w_ptr1] <= 1'b1;
            r_mem_we[w_ptr1]   <= a_we1;
            r_mem_addr[w_ptr1] <= a_addr1;
            r_mem_data[w_ptr1] <= a_we1 ? a_d1 : '0;
        end
    end

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push_n);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= r_count + CW'(w_push_n) - CW'(w_pop);
        end
    end

    // Profiling flags and counters; clr overrides any same-edge event.
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_conflict <= 1'b0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_drop_cnt <= '0;
        end else if (clr) begin
            r_overflow <= 1'b0;
            r_conflict <= 1'b0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (!w_accept) r_overflow <= 1'b1;
            if (w_hazard)  r_conflict <= 1'b1;
            r_rd_cnt   <= f_sat_add(r_rd_cnt, w_nrd);
            r_wr_cnt   <= f_sat_add(r_wr_cnt, w_nwr);
            r_drop_cnt <= f_sat_add(r_drop_cnt, w_ndrop);
        end
    end

    assign out_valid = r_count != '0;
    assign out_port  = r_mem_port[r_rd_ptr];
    assign out_we    = r_mem_we[r_rd_ptr];
    assign out_addr  = r_mem_addr[r_rd_ptr];
    assign out_data  = r_mem_data[r_rd_ptr];
    assign count     = r_count;
    assign stall     = r_count > C_STALL;
    assign overflow  = r_overflow;
    assign conflict  = r_conflict;
    assign rd_cnt    = r_rd_cnt;
    assign wr_cnt    = r_wr_cnt;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_kernel_req_capture.sv
// Scoreboard bench for kernel_req_capture: stimulus pushes expected
// entries, a negedge monitor pops and compares on each handshake.
module tb_kernel_req_capture;

    localparam int DEPTH = 8;

    logic        mod_clk;
    logic        reset;
    logic        clr;
    logic        a_ce0, a_we0, a_ce1, a_we1;
    logic [15:0] a_addr0, a_addr1;
    logic [31:0] a_d0, a_d1;
    logic        out_valid, out_ready, out_port, out_we;
    logic [15:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  count;
    logic        stall, overflow, conflict;
    logic [31:0] rd_cnt, wr_cnt, drop_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [49:0] q[$];
    logic [49:0] m_exp;

    kernel_req_capture dut (
        .mod_clk(mod_clk), .reset(reset), .clr(clr),
        .a_ce0(a_ce0), .a_we0(a_we0), .a_addr0(a_addr0), .a_d0(a_d0),
        .a_ce1(a_ce1), .a_we1(a_we1), .a_addr1(a_addr1), .a_d1(a_d1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_port(out_port), .out_we(out_we),
        .out_addr(out_addr), .out_data(out_data),
        .count(count), .stall(stall),
        .overflow(overflow), .conflict(conflict),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .drop_cnt(drop_cnt)
    );

    initial mod_clk = 1'b0;
    always #5 mod_clk = ~mod_clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: a handshake seen mid-cycle pops at the next rising edge.
    always @(negedge mod_clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_head got %0h want none",
                         {out_port, out_we, out_addr, out_data});
            end else begin
                m_exp = q.pop_front();
                chk("head", {14'd0, out_port, out_we, out_addr, out_data},
                    {14'd0, m_exp});
            end
        end
    end

    // One edge of stimulus; expected entries queued if there is room.
    task automatic step(input logic c0, input logic w0,
                        input logic [15:0] ad0, input logic [31:0] d0,
                        input logic c1, input logic w1,
                        input logic [15:0] ad1, input logic [31:0] d1,
                        input logic rdy, input logic cl);
        int n;
        n = int'(c0) + int'(c1);
        a_ce0 = c0; a_we0 = w0; a_addr0 = ad0; a_d0 = d0;
        a_ce1 = c1; a_we1 = w1; a_addr1 = ad1; a_d1 = d1;
        out_ready = rdy;
        clr = cl;
        if (n <= DEPTH - q.size()) begin
            if (c0) q.push_back({1'b0, w0, ad0, w0 ? d0 : 32'd0});
            if (c1) q.push_back({1'b1, w1, ad1, w1 ? d1 : 32'd0});
        end
        @(posedge mod_clk);
        #1;
        a_ce0 = 1'b0; a_ce1 = 1'b0; clr = 1'b0; out_ready = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        step(0, 0, 16'd0, 32'd0, 0, 0, 16'd0, 32'd0, rdy, 0);
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; out_ready = 1'b0;
        a_ce0 = 0; a_we0 = 0; a_addr0 = '0; a_d0 = '0;
        a_ce1 = 0; a_we1 = 0; a_addr1 = '0; a_d1 = '0;
        @(posedge mod_clk);
        @(posedge mod_clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_conf", conflict, 0);
        chk("rst_cnts", {rd_cnt, wr_cnt | drop_cnt}, 0);
        reset = 1'b0;

        // single read, data must be stored as zero
        step(1, 0, 16'h0010, 32'hDEAD, 0, 0, 16'd0, 32'd0, 0, 0);
        chk("rd_valid", out_valid, 1);
        chk("rd_count", count, 1);
        chk("rd_cnt1", rd_cnt, 1);
        idle(1);
        chk("rd_drain", count, 0);

        // dual write, port 0 ahead of port 1
        step(1, 1, 16'd5, 32'hAA, 1, 1, 16'd6, 32'hBB, 0, 0);
        chk("dw_wrcnt", wr_cnt, 2);
        chk("dw_conf", conflict, 0);
        chk("dw_count", count, 2);
        idle(1);
        idle(1);
        chk("dw_drain", count, 0);

        // fill with no consumer
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 16'h0100 + 16'(2*i), 32'd1,
                 1, 0, 16'h0101 + 16'(2*i), 32'd2, 0, 0);
            if (i == 2) begin
                chk("fill6_cnt", count, 6);
                chk("fill6_stall", stall, 0);
            end
        end
        chk("full_cnt", count, 8);
        chk("full_stall", stall, 1);
        chk("full_rdcnt", rd_cnt, 9);
        step(1, 0, 16'h0200, 32'd0, 1, 0, 16'h0201, 32'd0, 0, 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", drop_cnt, 2);
        chk("ovf_count", count, 8);

        // clr leaves queue alone
        step(0, 0, 16'd0, 32'd0, 0, 0, 16'd0, 32'd0, 0, 1);
        chk("clr_ovf", overflow, 0);
        chk("clr_drop", drop_cnt, 0);
        chk("clr_rd", rd_cnt, 0);
        chk("clr_count", count, 8);

        // count 7: two requests with a pop, no pop credit
        idle(1);
        chk("c7_count", count, 7);
        chk("c7_stall", stall, 1);
        step(1, 0, 16'h0300, 32'd0, 1, 0, 16'h0301, 32'd0, 1, 0);
        chk("pd_count", count, 6);
        chk("pd_drop", drop_cnt, 2);
        chk("pd_ovf", overflow, 1);
        chk("pd_rd", rd_cnt, 0);
        for (int i = 0; i < 6; i++) idle(1);
        chk("pd_drain", count, 0);
        chk("pd_stall", stall, 0);

        // same-address hazard, read queued first
        step(1, 0, 16'h0020, 32'h55, 1, 1, 16'h0020, 32'h77, 0, 0);
        chk("cf_flag", conflict, 1);
        chk("cf_count", count, 2);
        chk("cf_rdwr", {rd_cnt, wr_cnt}, {32'd1, 32'd1});
        // clr wins over a same-edge accepted read
        step(1, 0, 16'h0030, 32'h9, 0, 0, 16'd0, 32'd0, 0, 1);
        chk("cfc_flag", conflict, 0);
        chk("cfc_rdwr", {rd_cnt, wr_cnt}, 0);
        chk("cfc_ovf", overflow, 0);
        chk("cfc_count", count, 3);
        for (int i = 0; i < 3; i++) idle(1);
        chk("cf_drain", count, 0);

        // asynchronous reset mid-stream
        step(1, 1, 16'h0040, 32'h11, 1, 1, 16'h0041, 32'h22, 0, 0);
        step(1, 0, 16'h0042, 32'h33, 1, 0, 16'h0043, 32'h44, 0, 0);
        step(1, 0, 16'h0044, 32'h55, 0, 0, 16'd0, 32'd0, 0, 0);
        chk("mr_count", count, 5);
        chk("mr_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        q.delete();
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_count", count, 0);
        chk("ar_cnts", {rd_cnt, wr_cnt}, 0);
        chk("ar_stall", stall, 0);
        @(posedge mod_clk);
        #1;
        reset = 1'b0;
        step(0, 0, 16'd0, 32'd0, 1, 1, 16'h0099, 32'h1234, 0, 0);
        chk("ar_post_v", out_valid, 1);
        chk("ar_post_wr", wr_cnt, 1);
        idle(1);
        chk("ar_post_c", count, 0);

        chk("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
